// File: rtl/ex_operand_stage_pkg.sv
// Shared ALU op-code constants for the MIPS EX stage.
// OP_NOP is the op a freshly reset operand stage presents.
package ex_operand_stage_pkg;

   typedef logic [2:0] alu_op_t;

   localparam alu_op_t OP_AND = 3'b000;
   localparam alu_op_t OP_OR  = 3'b001;
   localparam alu_op_t OP_ADD = 3'b010;
   localparam alu_op_t OP_SUB = 3'b110;
   localparam alu_op_t OP_SLT = 3'b111;
   localparam alu_op_t OP_NOP = OP_ADD;

endpackage

// File: rtl/ex_operand_stage_fwd_mux.sv
// Operand forwarding select: EX/MEM beats MEM/WB, and register 0 is never forwarded.
module fwd_mux #(
   parameter int W  = 32,
   parameter int RW = 5
) (
   input  logic [RW-1:0] i_idx,
   input  logic [W-1:0]  i_held_val,
   input  logic          i_exm_en,
   input  logic [RW-1:0] i_exm_idx,
   input  logic [W-1:0]  i_exm_data,
   input  logic          i_wb_en,
   input  logic [RW-1:0] i_wb_idx,
   input  logic [W-1:0]  i_wb_data,
   output logic [W-1:0]  o_val
);

   logic w_nonzero;
   logic w_exm_hit;
   logic w_wb_hit;

   assign w_nonzero = (i_idx != {RW{1'b0}});
   assign w_exm_hit = i_exm_en && (i_exm_idx == i_idx) && w_nonzero;
   assign w_wb_hit  = i_wb_en  && (i_wb_idx  == i_idx) && w_nonzero;

   // Priority select of the newest producer
   always_comb begin
      o_val = i_held_val;
      if (w_exm_hit) begin
         o_val = i_exm_data;
      end else if (w_wb_hit) begin
         o_val = i_wb_data;
      end else begin
         o_val = i_held_val;
      end
   end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register: holds one decoded instruction, forwards operands into the ALU
// and inserts a single bubble when an instruction depends on the load it follows.
module ex_operand_stage
   import ex_operand_stage_pkg::*;
#(
   parameter int W  = 32,
   parameter int RW = 5
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [RW-1:0] in_rs_idx,
   input  logic [RW-1:0] in_rt_idx,
   input  logic [RW-1:0] in_rd_idx,
   input  logic [W-1:0]  in_rs_val,
   input  logic [W-1:0]  in_rt_val,
   input  logic [W-1:0]  in_imm,
   input  logic          in_use_imm,
   input  logic [2:0]    in_op,
   input  logic          in_reg_write,
   input  logic          in_mem_read,
   input  logic          flush,
   input  logic          exm_fwd_en,
   input  logic [RW-1:0] exm_fwd_idx,
   input  logic [W-1:0]  exm_fwd_data,
   input  logic          wb_fwd_en,
   input  logic [RW-1:0] wb_fwd_idx,
   input  logic [W-1:0]  wb_fwd_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [W-1:0]  a,
   output logic [W-1:0]  b,
   output logic [2:0]    op,
   output logic [RW-1:0] out_rd_idx,
   output logic          out_reg_write,
   output logic          out_mem_read,
   output logic [15:0]   bubble_cnt
);

   logic          r_valid;
   logic [RW-1:0] r_rs_idx;
   logic [RW-1:0] r_rt_idx;
   logic [RW-1:0] r_rd_idx;
   logic [W-1:0]  r_rs_val;
   logic [W-1:0]  r_rt_val;
   logic [W-1:0]  r_imm;
   logic          r_use_imm;
   alu_op_t       r_op;
   logic          r_reg_write;
   logic          r_mem_read;
   logic [15:0]   r_bubble_cnt;

   logic          w_load_use;
   logic          w_load;
   logic          w_out_hs;
   logic          w_cap_rs_hit;
   logic          w_cap_rt_hit;
   logic          w_hold_rs_hit;
   logic          w_hold_rt_hit;
   logic [W-1:0]  w_fwd_a;
   logic [W-1:0]  w_fwd_b;

   assign w_load_use = r_valid && r_mem_read && (r_rd_idx != {RW{1'b0}}) && in_valid &&
                       ((in_rs_idx == r_rd_idx) || (!in_use_imm && (in_rt_idx == r_rd_idx)));
   assign in_ready   = (!r_valid || out_ready) && !w_load_use && !flush;
   assign w_load     = in_valid && in_ready;
   assign w_out_hs   = r_valid && out_ready;

   // A register being written back this cycle must win over the stale register-file read
   assign w_cap_rs_hit  = wb_fwd_en && (wb_fwd_idx == in_rs_idx) && (in_rs_idx != {RW{1'b0}});
   assign w_cap_rt_hit  = wb_fwd_en && (wb_fwd_idx == in_rt_idx) && (in_rt_idx != {RW{1'b0}});
   assign w_hold_rs_hit = wb_fwd_en && (wb_fwd_idx == r_rs_idx)  && (r_rs_idx  != {RW{1'b0}});
   assign w_hold_rt_hit = wb_fwd_en && (wb_fwd_idx == r_rt_idx)  && (r_rt_idx  != {RW{1'b0}});

   fwd_mux #(.W(W), .RW(RW)) u_fwd_a (
      .i_idx      (r_rs_idx),
      .i_held_val (r_rs_val),
      .i_exm_en   (exm_fwd_en),
      .i_exm_idx  (exm_fwd_idx),
      .i_exm_data (exm_fwd_data),
      .i_wb_en    (wb_fwd_en),
      .i_wb_idx   (wb_fwd_idx),
      .i_wb_data  (wb_fwd_data),
      .o_val      (w_fwd_a)
   );

   fwd_mux #(.W(W), .RW(RW)) u_fwd_b (
      .i_idx      (r_rt_idx),
      .i_held_val (r_rt_val),
      .i_exm_en   (exm_fwd_en),
      .i_exm_idx  (exm_fwd_idx),
      .i_exm_data (exm_fwd_data),
      .i_wb_en    (wb_fwd_en),
      .i_wb_idx   (wb_fwd_idx),
      .i_wb_data  (wb_fwd_data),
      .o_val      (w_fwd_b)
   );

   // Held instruction: flush, then load, then drain, else refresh from MEM/WB while stalled
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_valid     <= 1'b0;
         r_rs_idx    <= {RW{1'b0}};
         r_rt_idx    <= {RW{1'b0}};
         r_rd_idx    <= {RW{1'b0}};
         r_rs_val    <= {W{1'b0}};
         r_rt_val    <= {W{1'b0}};
         r_imm       <= {W{1'b0}};
         r_use_imm   <= 1'b0;
         r_op        <= OP_NOP;
         r_reg_write <= 1'b0;
         r_mem_read  <= 1'b0;
      end else if (flush) begin
         r_valid <= 1'b0;
      end else if (w_load) begin
         r_valid     <= 1'b1;
         r_rs_idx    <= in_rs_idx;
         r_rt_idx    <= in_rt_idx;
         r_rd_idx    <= in_rd_idx;
         r_rs_val    <= w_cap_rs_hit ? wb_fwd_data : in_rs_val;
         r_rt_val    <= w_cap_rt_hit ? wb_fwd_data : in_rt_val;
         r_imm       <= in_imm;
         r_use_imm   <= in_use_imm;
         r_op        <= in_op;
         r_reg_write <= in_reg_write;
         r_mem_read  <= in_mem_read;
      end else if (w_out_hs) begin
         r_valid <= 1'b0;
      end else if (r_valid) begin
         if (w_hold_rs_hit) begin
            r_rs_val <= wb_fwd_data;
         end
         if (w_hold_rt_hit) begin
            r_rt_val <= wb_fwd_data;
         end
      end
   end

   // Saturating count of load-use bubbles actually handed to EX
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_bubble_cnt <= 16'd0;
      end else if (!flush && w_load_use && w_out_hs && (r_bubble_cnt != 16'hFFFF)) begin
         r_bubble_cnt <= r_bubble_cnt + 16'd1;
      end
   end

   // Operands are zeroed while empty so the ALU never sees X
   always_comb begin
      a = {W{1'b0}};
      b = {W{1'b0}};
      if (r_valid) begin
         a = w_fwd_a;
         b = r_use_imm ? r_imm : w_fwd_b;
      end else begin
         a = {W{1'b0}};
         b = {W{1'b0}};
      end
   end

   assign out_valid     = r_valid;
   assign op            = r_op;
   assign out_rd_idx    = r_rd_idx;
   assign out_reg_write = r_reg_write;
   assign out_mem_read  = r_mem_read;
   assign bubble_cnt    = r_bubble_cnt;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Scenario bench for ex_operand_stage with a scoreboard for random back-to-back traffic.
module tb_ex_operand_stage;

   localparam logic [2:0] C_AND = 3'b000;
   localparam logic [2:0] C_OR  = 3'b001;
   localparam logic [2:0] C_ADD = 3'b010;
   localparam logic [2:0] C_SUB = 3'b110;
   localparam logic [2:0] C_SLT = 3'b111;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        in_valid, in_ready;
   logic [4:0]  in_rs_idx, in_rt_idx, in_rd_idx;
   logic [31:0] in_rs_val, in_rt_val, in_imm;
   logic        in_use_imm;
   logic [2:0]  in_op;
   logic        in_reg_write, in_mem_read, flush;
   logic        exm_fwd_en;
   logic [4:0]  exm_fwd_idx;
   logic [31:0] exm_fwd_data;
   logic        wb_fwd_en;
   logic [4:0]  wb_fwd_idx;
   logic [31:0] wb_fwd_data;
   logic        out_valid, out_ready;
   logic [31:0] a, b;
   logic [2:0]  op;
   logic [4:0]  out_rd_idx;
   logic        out_reg_write, out_mem_read;
   logic [15:0] bubble_cnt;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [2:0]  op;
      logic [4:0]  rd;
   } exp_t;

   exp_t        sbq[$];
   int          total = 0;
   int          bad = 0;
   logic [15:0] exp_bub = 16'd0;

   always #5 clk = ~clk;

   ex_operand_stage #(.W(32), .RW(5)) dut (
      .clk(clk), .reset_n(reset_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_rs_idx(in_rs_idx), .in_rt_idx(in_rt_idx), .in_rd_idx(in_rd_idx),
      .in_rs_val(in_rs_val), .in_rt_val(in_rt_val), .in_imm(in_imm),
      .in_use_imm(in_use_imm), .in_op(in_op),
      .in_reg_write(in_reg_write), .in_mem_read(in_mem_read), .flush(flush),
      .exm_fwd_en(exm_fwd_en), .exm_fwd_idx(exm_fwd_idx), .exm_fwd_data(exm_fwd_data),
      .wb_fwd_en(wb_fwd_en), .wb_fwd_idx(wb_fwd_idx), .wb_fwd_data(wb_fwd_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .a(a), .b(b), .op(op), .out_rd_idx(out_rd_idx),
      .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
      .bubble_cnt(bubble_cnt)
   );

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      in_valid = 1'b0; in_rs_idx = 5'd0; in_rt_idx = 5'd0; in_rd_idx = 5'd0;
      in_rs_val = 32'd0; in_rt_val = 32'd0; in_imm = 32'd0; in_use_imm = 1'b0;
      in_op = C_ADD; in_reg_write = 1'b0; in_mem_read = 1'b0; flush = 1'b0;
      exm_fwd_en = 1'b0; exm_fwd_idx = 5'd0; exm_fwd_data = 32'd0;
      wb_fwd_en = 1'b0; wb_fwd_idx = 5'd0; wb_fwd_data = 32'd0;
      out_ready = 1'b0;
   endtask

   task automatic drive(input logic [4:0] rs, input logic [31:0] rsv,
                        input logic [4:0] rt, input logic [31:0] rtv,
                        input logic [4:0] rd, input logic [2:0] o,
                        input logic ui, input logic [31:0] im, input logic mr);
      in_valid = 1'b1; in_rs_idx = rs; in_rs_val = rsv; in_rt_idx = rt; in_rt_val = rtv;
      in_rd_idx = rd; in_op = o; in_use_imm = ui; in_imm = im; in_mem_read = mr;
      in_reg_write = 1'b1;
   endtask

   task automatic test_reset_state();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0h want=0", out_valid); end
      total++; if (op !== C_ADD) begin bad++; $display("FAIL rst_op got=%b want=%b", op, C_ADD); end
      total++; if (bubble_cnt !== 16'd0) begin bad++; $display("FAIL rst_bub got=%0d want=0", bubble_cnt); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%0h want=1", in_ready); end
   endtask

   task automatic test_plain();
      out_ready = 1'b1;
      drive(5'd3, 32'd5, 5'd4, 32'd7, 5'd2, C_SUB, 1'b0, 32'd0, 1'b0);
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL plain_in_ready got=%0h want=1", in_ready); end
      cyc();
      in_valid = 1'b0;
      #1;
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL plain_valid got=%0h want=1", out_valid); end
      total++; if (a !== 32'd5) begin bad++; $display("FAIL plain_a got=%h want=%h", a, 32'd5); end
      total++; if (b !== 32'd7) begin bad++; $display("FAIL plain_b got=%h want=%h", b, 32'd7); end
      total++; if (op !== C_SUB) begin bad++; $display("FAIL plain_op got=%b want=%b", op, C_SUB); end
      total++; if (out_rd_idx !== 5'd2) begin bad++; $display("FAIL plain_rd got=%0d want=2", out_rd_idx); end
      cyc();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL plain_drain got=%0h want=0", out_valid); end
   endtask

   task automatic test_fwd_priority();
      out_ready = 1'b0;
      drive(5'd8, 32'd1, 5'd0, 32'd0, 5'd3, C_ADD, 1'b0, 32'd0, 1'b0);
      cyc();
      in_valid = 1'b0;
      exm_fwd_en = 1'b1; exm_fwd_idx = 5'd8; exm_fwd_data = 32'hAA;
      wb_fwd_en = 1'b1; wb_fwd_idx = 5'd8; wb_fwd_data = 32'hBB;
      #1;
      total++; if (a !== 32'hAA) begin bad++; $display("FAIL fwd_exm_wins got=%h want=%h", a, 32'hAA); end
      total++; if (b !== 32'h0) begin bad++; $display("FAIL fwd_b_idx0 got=%h want=0", b); end
      exm_fwd_en = 1'b0;
      #1;
      total++; if (a !== 32'hBB) begin bad++; $display("FAIL fwd_wb got=%h want=%h", a, 32'hBB); end
      wb_fwd_en = 1'b0;
      #1;
      total++; if (a !== 32'h1) begin bad++; $display("FAIL fwd_none got=%h want=1", a); end
      out_ready = 1'b1;
      cyc();
      out_ready = 1'b0;
      drive(5'd0, 32'd0, 5'd0, 32'd0, 5'd3, C_OR, 1'b0, 32'd0, 1'b0);
      cyc();
      in_valid = 1'b0;
      exm_fwd_en = 1'b1; exm_fwd_idx = 5'd0; exm_fwd_data = 32'hAA;
      wb_fwd_en = 1'b1; wb_fwd_idx = 5'd0; wb_fwd_data = 32'hBB;
      #1;
      total++; if (a !== 32'h0) begin bad++; $display("FAIL fwd_idx0_a got=%h want=0", a); end
      total++; if (b !== 32'h0) begin bad++; $display("FAIL fwd_idx0_b got=%h want=0", b); end
      clr();
      out_ready = 1'b1;
      cyc();
   endtask

   task automatic test_load_use();
      out_ready = 1'b0;
      drive(5'd1, 32'h10, 5'd9, 32'd0, 5'd9, C_ADD, 1'b1, 32'd4, 1'b1);
      cyc();
      drive(5'd9, 32'h55, 5'd2, 32'h66, 5'd10, C_AND, 1'b0, 32'd0, 1'b0);
      out_ready = 1'b1;
      #1;
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL lu_in_ready got=%0h want=0", in_ready); end
      total++; if (b !== 32'd4) begin bad++; $display("FAIL lu_lw_b got=%h want=4", b); end
      total++; if (out_mem_read !== 1'b1) begin bad++; $display("FAIL lu_mem_read got=%0h want=1", out_mem_read); end
      cyc();
      exp_bub = exp_bub + 16'd1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL lu_bubble got=%0h want=0", out_valid); end
      total++; if (bubble_cnt !== exp_bub) begin bad++; $display("FAIL lu_cnt got=%0d want=%0d", bubble_cnt, exp_bub); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL lu_retry_ready got=%0h want=1", in_ready); end
      cyc();
      in_valid = 1'b0;
      #1;
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL lu_accept got=%0h want=1", out_valid); end
      total++; if (a !== 32'h55) begin bad++; $display("FAIL lu_a got=%h want=%h", a, 32'h55); end
      total++; if (b !== 32'h66) begin bad++; $display("FAIL lu_b got=%h want=%h", b, 32'h66); end
      cyc();
   endtask

   task automatic test_stall_refresh();
      out_ready = 1'b0;
      drive(5'd1, 32'h11, 5'd6, 32'h0, 5'd7, C_SLT, 1'b0, 32'd0, 1'b0);
      cyc();
      in_valid = 1'b0;
      cyc();
      wb_fwd_en = 1'b1; wb_fwd_idx = 5'd6; wb_fwd_data = 32'h1234;
      cyc();
      wb_fwd_en = 1'b0;
      cyc();
      out_ready = 1'b1;
      #1;
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL stall_valid got=%0h want=1", out_valid); end
      total++; if (b !== 32'h1234) begin bad++; $display("FAIL stall_b got=%h want=%h", b, 32'h1234); end
      total++; if (a !== 32'h11) begin bad++; $display("FAIL stall_a got=%h want=%h", a, 32'h11); end
      cyc();
   endtask

   task automatic test_flush();
      out_ready = 1'b0;
      drive(5'd1, 32'h10, 5'd0, 32'd0, 5'd9, C_ADD, 1'b1, 32'd8, 1'b1);
      cyc();
      drive(5'd9, 32'h77, 5'd3, 32'h88, 5'd12, C_OR, 1'b0, 32'd0, 1'b0);
      out_ready = 1'b1;
      flush = 1'b1;
      #1;
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_in_ready got=%0h want=0", in_ready); end
      cyc();
      flush = 1'b0;
      in_valid = 1'b0;
      #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%0h want=0", out_valid); end
      total++; if (bubble_cnt !== exp_bub) begin bad++; $display("FAIL flush_cnt got=%0d want=%0d", bubble_cnt, exp_bub); end
      cyc();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_not_taken got=%0h want=0", out_valid); end
   endtask

   task automatic test_back_to_back();
      logic        m_valid;
      logic        exp_rdy;
      exp_t        e;
      logic [2:0]  ops [5];
      ops[0] = C_AND; ops[1] = C_OR; ops[2] = C_ADD; ops[3] = C_SUB; ops[4] = C_SLT;
      m_valid = 1'b0;
      for (int i = 0; i < 80; i++) begin
         clr();
         out_ready = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 3) != 0) begin
            drive(5'($urandom_range(1, 31)), $urandom, 5'($urandom_range(1, 31)), $urandom,
                  5'($urandom_range(0, 31)), ops[$urandom_range(0, 4)],
                  1'($urandom_range(0, 1)), $urandom, 1'b0);
         end
         #1;
         exp_rdy = !m_valid || out_ready;
         total++; if (in_ready !== exp_rdy) begin bad++; $display("FAIL b2b_in_ready[%0d] got=%0h want=%0h", i, in_ready, exp_rdy); end
         total++; if (out_valid !== m_valid) begin bad++; $display("FAIL b2b_valid[%0d] got=%0h want=%0h", i, out_valid, m_valid); end
         if (m_valid && out_ready) begin
            total++;
            if (sbq.size() == 0) begin
               bad++; $display("FAIL b2b_empty_q[%0d] got=output want=none", i);
            end else begin
               e = sbq.pop_front();
               if (a !== e.a || b !== e.b || op !== e.op || out_rd_idx !== e.rd) begin
                  bad++;
                  $display("FAIL b2b_data[%0d] got=%h/%h/%b/%0d want=%h/%h/%b/%0d",
                           i, a, b, op, out_rd_idx, e.a, e.b, e.op, e.rd);
               end
            end
         end
         if (in_valid && exp_rdy) begin
            e.a = in_rs_val; e.b = in_use_imm ? in_imm : in_rt_val; e.op = in_op; e.rd = in_rd_idx;
            sbq.push_back(e);
            m_valid = 1'b1;
         end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
         end
         cyc();
      end
      clr();
      out_ready = 1'b1;
      #1;
      if (m_valid) begin
         total++;
         e = sbq.pop_front();
         if (a !== e.a || b !== e.b || op !== e.op) begin
            bad++; $display("FAIL b2b_drain got=%h/%h/%b want=%h/%h/%b", a, b, op, e.a, e.b, e.op);
         end
      end
      cyc();
      total++; if (sbq.size() != 0) begin bad++; $display("FAIL b2b_left got=%0d want=0", sbq.size()); end
   endtask

   task automatic test_reset();
      out_ready = 1'b0;
      drive(5'd3, 32'h99, 5'd4, 32'h98, 5'd5, C_SUB, 1'b0, 32'd0, 1'b0);
      cyc();
      in_valid = 1'b0;
      #3;
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rstm_pre got=%0h want=1", out_valid); end
      reset_n = 1'b0;
      #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstm_valid got=%0h want=0", out_valid); end
      total++; if (bubble_cnt !== 16'd0) begin bad++; $display("FAIL rstm_bub got=%0d want=0", bubble_cnt); end
      total++; if (a !== 32'd0 || b !== 32'd0) begin bad++; $display("FAIL rstm_ab got=%h/%h want=0/0", a, b); end
      total++; if (op !== C_ADD) begin bad++; $display("FAIL rstm_op got=%b want=%b", op, C_ADD); end
      cyc();
      reset_n = 1'b1;
      cyc();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstm_after got=%0h want=0", out_valid); end
   endtask

   initial begin
      reset_n = 1'b0;
      clr();
      cyc();
      cyc();
      reset_n = 1'b1;
      cyc();
      test_reset_state();
      test_plain();
      test_fwd_priority();
      test_load_use();
      test_stall_refresh();
      test_flush();
      test_back_to_back();
      test_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
